// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad key FIFO
package keypad_pkg;

  typedef enum logic [2:0] {
    POLL   = 3'd0,
    READ   = 3'd1,
    CAPT   = 3'd2,
    CLR    = 3'd3,
    SETTLE = 3'd4
  } poll_state_e;

  localparam logic KP_ADDR_DATA = 1'b0;
  localparam logic KP_ADDR_STAT = 1'b1;

  localparam int ST_OVF   = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_EMPTY = 5;

  function automatic logic [15:0] status_word(input logic ovf, input logic full,
                                              input logic empty, input logic [3:0] cnt);
    logic [15:0] w;
    w           = {12'b0, cnt};
    w[ST_OVF]   = ovf;
    w[ST_FULL]  = full;
    w[ST_EMPTY] = empty;
    return w;
  endfunction

endpackage

// File: rtl/keypad_fifo_mem.sv
// rtl/keypad_fifo_mem.sv - DEPTH x 4 key-code storage with pointers, count and full/empty
module keypad_fifo_mem
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       wr_data,
  output logic [3:0]       rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       mem_q [DEPTH];
  logic [3:0]       mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/keypad_key_fifo.sv
// rtl/keypad_key_fifo.sv - polls the keypad scanner, buffers key codes, CPU read port
// Optional registered key-available interrupt under `define KEYPAD_FIFO_IRQ_EN.
module keypad_key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] kp_data_in,
  output logic        kp_a0,
  output logic        kp_readyclr,
  input  logic        cpu_addr,
  input  logic        cpu_pop,
  input  logic        cpu_ovf_clr,
  output logic [15:0] cpu_data_out,
  output logic        irq
);

  poll_state_e      state_q, state_d;
  logic             kp_a0_q, kp_a0_d;
  logic             kp_readyclr_q, kp_readyclr_d;
  logic             ovf_q, ovf_d;
  logic             push, overflow;
  logic [3:0]       head_code;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             unused_kp_bits;

  assign unused_kp_bits = &{1'b0, kp_data_in[15:4]};

  assign kp_a0       = kp_a0_q;
  assign kp_readyclr = kp_readyclr_q;

  assign push     = (state_q == CAPT);
  assign overflow = push && full && !cpu_pop;

  keypad_fifo_mem #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (cpu_pop),
    .wr_data (kp_data_in[3:0]),
    .rd_data (head_code),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Select changes one state ahead of sampling so the scanner mux has settled.
  always_comb begin
    state_d       = state_q;
    kp_a0_d       = kp_a0_q;
    kp_readyclr_d = 1'b0;
    case (state_q)
      POLL: begin
        kp_a0_d = 1'b1;
        if (kp_data_in[0]) begin
          state_d = READ;
          kp_a0_d = 1'b0;
        end
      end
      READ: begin
        kp_a0_d = 1'b0;
        state_d = CAPT;
      end
      CAPT: begin
        kp_readyclr_d = 1'b1;
        state_d       = CLR;
      end
      CLR: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        kp_a0_d = 1'b1;
        state_d = POLL;
      end
      default: begin
        kp_a0_d = 1'b1;
        state_d = POLL;
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (cpu_ovf_clr) ovf_d = 1'b0;
    if (overflow)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= POLL;
      kp_a0_q       <= 1'b1;
      kp_readyclr_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      kp_a0_q       <= kp_a0_d;
      kp_readyclr_q <= kp_readyclr_d;
      ovf_q         <= ovf_d;
    end
  end

  always_comb begin
    if (cpu_addr == KP_ADDR_STAT) begin
      cpu_data_out = status_word(ovf_q, full, empty, 4'(count));
    end else begin
      cpu_data_out = empty ? 16'h0000 : {12'b0, head_code};
    end
  end

`ifdef KEYPAD_FIFO_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = !empty || ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
